sbox_layer_ctrl: RTL

//  Sequencer that pushes a WIDTH-bit cipher state through a small pool of shared SBox

---
 rtl/sbox_layer_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sbox_layer_ctrl.sv
// Iterative SBox substitution layer: rotates a WIDTH-bit state through LANES shared 4-bit SBoxes.
// Optional inverse-table support is enabled by defining SBOX_INV_EN (adds the in_inv port).
module sbox_layer_ctrl #(
  parameter int WIDTH = 64,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
`ifdef SBOX_INV_EN
  input  logic             in_inv,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int NSTEPS    = WIDTH / (4 * LANES);
  localparam int STEP_BITS = $clog2(NSTEPS + 1);
  localparam int LB        = 4 * LANES;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [WIDTH-1:0]       r_work;
  logic [WIDTH-1:0]       w_rot;
  logic [WIDTH-1:0]       r_out_data;
  logic [LB-1:0]          w_sub;
  logic [STEP_BITS-1:0]   r_step;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic                   r_busy;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_handshake;

  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  4'hF: y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

`ifdef SBOX_INV_EN
  logic r_inv;

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  4'hF: y = 4'hA;
      default: y = 4'h0;
    endcase
    return y;
  endfunction
`endif

  for (genvar k = 0; k < LANES; k++) begin : g_lane
`ifdef SBOX_INV_EN
    assign w_sub[4*k +: 4] = r_inv ? sbox_inv(r_work[4*k +: 4]) : sbox_fwd(r_work[4*k +: 4]);
`else
    assign w_sub[4*k +: 4] = sbox_fwd(r_work[4*k +: 4]);
`endif
  end

  // With a single step the whole word is replaced; otherwise substituted nibbles enter at the top.
  if (NSTEPS == 1) begin : g_one_step
    assign w_rot = w_sub;
  end else begin : g_multi_step
    assign w_rot = {w_sub, r_work[WIDTH-1:LB]};
  end

  assign w_accept    = (r_state == S_IDLE) && in_valid && r_in_ready;
  assign w_last      = (r_step == STEP_BITS'(NSTEPS - 1));
  assign w_handshake = (r_state == S_DONE) && out_ready;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)    w_state_next = S_RUN;  else w_state_next = S_IDLE;
      S_RUN:   if (w_last)      w_state_next = S_DONE; else w_state_next = S_RUN;
      S_DONE:  if (w_handshake) w_state_next = S_IDLE; else w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath and registered handshake outputs, aligned with the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_work      <= {WIDTH{1'b0}};
      r_step      <= {STEP_BITS{1'b0}};
      r_out_data  <= {WIDTH{1'b0}};
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SBOX_INV_EN
      r_inv       <= 1'b0;
`endif
    end else begin
      r_in_ready  <= (w_state_next == S_IDLE);
      r_out_valid <= (w_state_next == S_DONE);
      r_busy      <= (w_state_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_work <= in_data;
            r_step <= {STEP_BITS{1'b0}};
`ifdef SBOX_INV_EN
            r_inv  <= in_inv;
`endif
          end
        end
        S_RUN: begin
          r_work <= w_rot;
          r_step <= r_step + STEP_BITS'(1);
          if (w_last) begin
            r_out_data <= w_rot;
          end
        end
        S_DONE: begin
          r_work <= r_work;
        end
        default: begin
          r_work <= {WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule
